// File: rtl/serial_word_transmitter_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding and
// the default parallel word width.
package serial_word_transmitter_pkg;

   localparam int DEFAULT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_word_transmitter_bit_down_counter.sv
// Bit counter for the serializer: loads the index of the last bit and counts
// down once per accepted bit, saturating at zero.
module bit_down_counter #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          dec_en,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_r;

   // Counter register; load wins over decrement, never decrements past zero.
   always_ff @(posedge clk) begin
      if (srst) begin
         count_r <= {CW{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (dec_en && (count_r != {CW{1'b0}})) begin
         count_r <= count_r - CW'(1'b1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/serial_word_transmitter.sv
// Parallel-to-serial word transmitter with valid/ready handshake on both sides.
// Outputs are decoded purely from the state, shift and counter registers.
module serial_word_transmitter
   import serial_word_transmitter_pkg::*;
#(
   parameter int W         = DEFAULT_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset_synchronous,
   input  logic         load_valid,
   input  logic [W-1:0] inp_word,
   output logic         load_ready,
   input  logic         ser_ready,
   output logic         ser_out,
   output logic         ser_valid,
   output logic         last_bit,
   output logic         done
);

   localparam int CW = $clog2(W);

   state_e        state_r;
   state_e        next_state_s;
   logic [W-1:0]  shift_r;
   logic [CW-1:0] count_s;
   logic          accept_s;
   logic          xfer_s;
   logic          cnt_zero_s;

   assign accept_s   = (state_r == IDLE) && load_valid;
   assign xfer_s     = (state_r == SHIFT) && ser_ready;
   assign cnt_zero_s = (count_s == {CW{1'b0}});

   bit_down_counter #(.CW(CW)) u_counter (
      .clk        (clk),
      .srst       (reset_synchronous),
      .load       (accept_s),
      .load_value (CW'(W - 1)),
      .dec_en     (xfer_s),
      .count      (count_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset_synchronous) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (load_valid) next_state_s = SHIFT;
            else            next_state_s = IDLE;
         end
         SHIFT: begin
            if (ser_ready && cnt_zero_s) next_state_s = DONE;
            else                         next_state_s = SHIFT;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Shift register moves toward the output end with zero fill, only on a transfer.
   always_ff @(posedge clk) begin
      if (reset_synchronous) begin
         shift_r <= {W{1'b0}};
      end else if (accept_s) begin
         shift_r <= inp_word;
      end else if (xfer_s) begin
         if (MSB_FIRST) shift_r <= {shift_r[W-2:0], 1'b0};
         else           shift_r <= {1'b0, shift_r[W-1:1]};
      end else begin
         shift_r <= shift_r;
      end
   end

   // Output decode from registered state.
   always_comb begin
      load_ready = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      last_bit   = 1'b0;
      done       = 1'b0;
      case (state_r)
         IDLE:  load_ready = 1'b1;
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = MSB_FIRST ? shift_r[W-1] : shift_r[0];
            last_bit  = cnt_zero_s;
         end
         DONE:    done = 1'b1;
         default: load_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against a word/bit-index reference model.
module tb_serial_word_transmitter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lv  = 1'b0;
   logic       sr  = 1'b1;
   logic [3:0] word = 4'b0000;
   logic       lr_m, sv_m, so_m, lb_m, dn_m;
   logic       lr_l, sv_l, so_l, lb_l, dn_l;

   int         n_chk = 0;
   int         n_err = 0;

   // reference model: word in flight, bits still to send, done phase
   int         left  = 0;
   logic [3:0] mword = 4'b0000;
   bit         mdone = 1'b0;

   always #5 clk = ~clk;

   serial_word_transmitter #(.W(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset_synchronous(rst), .load_valid(lv), .inp_word(word),
      .load_ready(lr_m), .ser_ready(sr), .ser_out(so_m), .ser_valid(sv_m),
      .last_bit(lb_m), .done(dn_m));

   serial_word_transmitter #(.W(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset_synchronous(rst), .load_valid(lv), .inp_word(word),
      .load_ready(lr_l), .ser_ready(sr), .ser_out(so_l), .ser_valid(sv_l),
      .last_bit(lb_l), .done(dn_l));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         left  = 0;
         mdone = 1'b0;
      end else if (mdone) begin
         mdone = 1'b0;
      end else if (left > 0) begin
         if (sr) begin
            left--;
            if (left == 0) mdone = 1'b1;
         end
      end else if (lv) begin
         mword = word;
         left  = 4;
      end
   endtask

   // {load_ready, ser_valid, ser_out, last_bit, done}
   function automatic logic [4:0] expect_out(input bit msb);
      int   k;
      logic b;
      k = 4 - left;
      b = 1'b0;
      if (left > 0) b = msb ? mword[3-k] : mword[k];
      return {(left == 0) && !mdone, left > 0, b, left == 1, mdone};
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_val("cyc_msb", 32'({lr_m, sv_m, so_m, lb_m, dn_m}), 32'(expect_out(1'b1)));
      check_val("cyc_lsb", 32'({lr_l, sv_l, so_l, lb_l, dn_l}), 32'(expect_out(1'b0)));
   endtask

   initial begin
      logic [3:0] seq_m;
      logic [3:0] seq_l;
      logic [3:0] got;
      logic       eb_m;
      logic       eb_l;
      int         nv;
      bit         seen;

      seq_m = 4'b1011;
      seq_l = 4'b1101;

      // reset
      rst = 1'b1; lv = 1'b1; word = 4'b1011; sr = 1'b1;
      tick();
      check_val("rst_state_m", 32'({lr_m, sv_m, so_m, lb_m, dn_m}), 32'(5'b10000));
      check_val("rst_state_l", 32'({lr_l, sv_l, so_l, lb_l, dn_l}), 32'(5'b10000));
      rst = 1'b0;

      // basic word, both bit orders, with latency markers
      lv = 1'b1; word = 4'b1011;
      tick();
      lv = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         eb_m = 1'b0;
         eb_l = 1'b0;
         if (c <= 4) begin
            eb_m = seq_m[4-c];
            eb_l = seq_l[4-c];
         end
         check_val("basic_m", 32'({so_m, lb_m, dn_m, lr_m}), 32'({eb_m, c == 4, c == 5, c == 6}));
         check_val("basic_l", 32'({so_l, lb_l, dn_l, lr_l}), 32'({eb_l, c == 4, c == 5, c == 6}));
         tick();
      end

      // stall three cycles after the second bit
      lv = 1'b1; word = 4'b1011; sr = 1'b1;
      tick();
      lv = 1'b0;
      nv = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (dn_m) begin
            seen = 1'b1;
         end else begin
            if (sv_m) nv++;
            if (i >= 2 && i <= 4) check_val("stall_hold", 32'({sv_m, so_m}), 32'(2'b10));
            sr = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            tick();
         end
      end
      sr = 1'b1;
      check_val("stall_done", 32'(seen), 32'(1'b1));
      check_val("stall_len", 32'(nv), 32'd7);
      tick();

      // load attempt during shift is ignored
      lv = 1'b1; word = 4'b1011;
      tick();
      word = 4'b0110;
      got = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         got = {got[2:0], so_m};
         tick();
      end
      check_val("ignore_load", 32'(got), 32'(4'b1011));
      lv = 1'b0;
      tick();
      tick();

      // reset mid-word
      lv = 1'b1; word = 4'b1011;
      tick();
      lv = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_abort", 32'({lr_m, sv_m, dn_m}), 32'(3'b100));
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("no_done", 32'({dn_m, dn_l}), 32'(2'b00));
      end

      // back-to-back words with load_valid held
      lv = 1'b1; word = 4'b1111;
      tick();
      word = 4'b0001;
      for (int c = 1; c <= 7; c++) begin
         if (c == 6) check_val("b2b_ready", 32'({lr_m, sv_m}), 32'(2'b10));
         if (c == 7) check_val("b2b_first", 32'({sv_m, so_m, so_l}), 32'(3'b101));
         tick();
      end
      lv = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 39) == 0);
         lv   = $urandom_range(0, 1) == 1;
         word = 4'($urandom);
         sr   = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_word_transmitter.md
SERIAL_WORD_TRANSMITTER -- requirements
Module: serial_word_transmitter

Interface
REQ-001 SHALL have parameter W, default 4, parallel word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit W-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_synchronous, input, 1, synchronous active-high reset; takes effect at the next rising edge of clk.
REQ-005 SHALL have port load_valid, input, 1, upstream offers inp_word this cycle.
REQ-006 SHALL have port inp_word, input, W, parallel word to be serialized.
REQ-007 SHALL have port load_ready, output, 1, block accepts a word this cycle.
REQ-008 SHALL have port ser_ready, input, 1, downstream receiver accepts ser_out this cycle.
REQ-009 SHALL have port ser_out, output, 1, current serial bit.
REQ-010 SHALL have port ser_valid, output, 1, ser_out holds a valid bit.
REQ-011 SHALL have port last_bit, output, 1, the current valid bit is the final bit of the word.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last bit is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE: load_ready = 1; ser_valid = 0; done = 0.
REQ-015 In IDLE with load_valid = 1 at an edge: inp_word SHALL be captured into a W-bit shift register, the bit counter set to W-1, and the state changed to SHIFT.
REQ-016 In SHIFT: load_ready = 0; ser_valid = 1; ser_out = shift_reg[W-1] if MSB_FIRST, otherwise shift_reg[0].
REQ-017 A bit transfer SHALL occur on an edge where ser_valid = 1 and ser_ready = 1; only then does the shift register shift by one toward the output end (zero fill) and the counter decrement.
REQ-018 In SHIFT with ser_ready = 0: shift register, counter and ser_out SHALL hold unchanged, with no bit loss or duplication.
REQ-019 last_bit SHALL be 1 only in SHIFT with counter = 0.
REQ-020 A transfer with counter = 0 SHALL move the state to DONE.
REQ-021 In DONE: done = 1, load_ready = 0, ser_valid = 0; the state SHALL unconditionally return to IDLE at the next edge.
REQ-022 Latency with ser_ready held 1: the first bit appears the cycle after acceptance; the W bits occupy W consecutive cycles; done occurs in cycle W+1; load_ready = 1 again in cycle W+2.
REQ-023 load_valid SHALL be ignored outside IDLE; inp_word changes outside IDLE SHALL not affect the word in flight.
REQ-024 The counter SHALL be $clog2(W) bits wide and SHALL never wrap below 0.
REQ-025 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-026 On reset_synchronous = 1 at an edge: state = IDLE, shift register = 0, counter = 0.
REQ-027 After reset: load_ready = 1, ser_valid = 0, ser_out = 0, last_bit = 0, done = 0.
REQ-028 Reset SHALL take priority over load_valid and ser_ready in the same cycle.
REQ-029 Reset during SHIFT or DONE SHALL abort the word with no done pulse.

Structure
REQ-030 State encoding constants (IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10) SHALL reside in a shared package, together with the default width.
REQ-031 The bit counter SHALL be a sub-module, bit_down_counter, with synchronous reset, load and decrement-enable.
REQ-032 The FSM, shift register and output decode SHALL reside in serial_word_transmitter.

Verification
REQ-033 Bench SHALL cover: W=4, MSB_FIRST=1, inp_word=4'b1011, ser_ready=1 -> ser_out 1,0,1,1 on cycles 1-4; last_bit on cycle 4; done on cycle 5; load_ready on cycle 6.
REQ-034 Bench SHALL cover: MSB_FIRST=0, inp_word=4'b1011 -> ser_out 1,1,0,1.
REQ-035 Bench SHALL cover: ser_ready=0 for 3 cycles after the second bit -> second bit held stable for 3 extra cycles; total word takes 7 cycles; sequence unchanged.
REQ-036 Bench SHALL cover: load_valid=1 with inp_word=4'b0110 during SHIFT of 4'b1011 -> ignored; output remains 1,0,1,1.
REQ-037 Bench SHALL cover: reset_synchronous=1 after the second bit -> next cycle IDLE, ser_valid=0, no done pulse, load_ready=1.
REQ-038 Bench SHALL cover: back-to-back words 4'b1111 then 4'b0001 with load_valid held 1 -> second word accepted exactly in the first IDLE cycle after done.
